// File: rtl/falafel_pkg.sv
// Shared constants for the falafel response path.
package falafel_pkg;
   localparam int DATA_W = 8;
endpackage

// File: rtl/falafel_resp_fifo.sv
// Show-ahead response FIFO with sticky overflow/underflow flags and synchronous flush.
// Status outputs decode only from the registered occupancy count.
module falafel_resp_fifo #(
   parameter int DATA_W   = falafel_pkg::DATA_W,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        din_i,
   output logic                     full_o,
   output logic                     almost_full_o,
   input  logic                     read_i,
   output logic                     empty_o,
   output logic [DATA_W-1:0]        dout_o,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o,
   input  logic                     err_clr_i,
   output logic                     overflow_o,
   output logic                     underflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic full_s, empty_s, push_ok_s, pop_ok_s, ovf_evt_s, unf_evt_s;

   // Accept decisions, next-state pointers, count and sticky flags
   always_comb begin
      full_s    = (count_q == DEPTH_C);
      empty_s   = (count_q == {CNT_W{1'b0}});
      push_ok_s = push_i && !full_s;
      pop_ok_s  = read_i && !empty_s;
      // Errors are only raised for requests that flush does not override.
      ovf_evt_s = !flush_i && push_i && full_s;
      unf_evt_s = !flush_i && read_i && empty_s;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (flush_i) begin
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
         count_d  = {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end

      ovf_d = (ovf_q && !err_clr_i) || ovf_evt_s;
      unf_d = (unf_q && !err_clr_i) || unf_evt_s;
   end

   // Control state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage array; deliberately not reset
   always_ff @(posedge clk_i) begin
      if (!flush_i && push_ok_s) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   assign full_o        = full_s;
   assign empty_o       = empty_s;
   assign almost_full_o = (count_q >= AF_C);
   assign count_o       = count_q;
   assign dout_o        = mem_q[rd_ptr_q];
   assign overflow_o    = ovf_q;
   assign underflow_o   = unf_q;

endmodule

// File: doc/falafel_resp_fifo.md
FALAFEL_RESP_FIFO -- requirements
Module: falafel_resp_fifo

Interface
REQ-001 Parameter DATA_W, from falafel_pkg: response word width.
REQ-002 Parameter DEPTH, default 8: entry count; power of two, >= 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost-full threshold, 1..DEPTH.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset; asynchronous, active-low.
REQ-006 push_i  in  1  write request from the response producer.
REQ-007 din_i  in  DATA_W  write data.
REQ-008 full_o  out  1  no free entry.
REQ-009 almost_full_o  out  1  count >= AF_LEVEL.
REQ-010 read_i  in  1  pop request from the output FSM.
REQ-011 empty_o  out  1  no valid entry.
REQ-012 dout_o  out  DATA_W  head entry, show-ahead.
REQ-013 flush_i  in  1  synchronous discard of all entries.
REQ-014 count_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-015 err_clr_i  in  1  clears sticky error flags.
REQ-016 overflow_o  out  1  sticky: push dropped while full.
REQ-017 underflow_o  out  1  sticky: pop requested while empty.

Function
REQ-018 Storage: DEPTH x DATA_W array, write pointer wr_ptr, read pointer rd_ptr, occupancy count; both pointers $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-019 full_o = (count == DEPTH), empty_o = (count == 0), almost_full_o = (count >= AF_LEVEL), all decoded from registered count only, with no combinational path from push_i or read_i.
REQ-020 dout_o = mem[rd_ptr] combinationally (show-ahead); it is valid whenever empty_o = 0, so the consumer uses it in the same cycle it asserts read_i.
REQ-021 dout_o is don't-care while empty_o = 1; benches do not check it then.
REQ-022 Push accepted iff push_i && !full_o: mem[wr_ptr] <= din_i, wr_ptr increments.
REQ-023 Pop accepted iff read_i && !empty_o: rd_ptr increments.
REQ-024 A push while full is dropped, leaves state unchanged and sets overflow_o, even when a pop occurs in the same cycle.
REQ-025 A pop while empty is ignored and sets underflow_o.
REQ-026 Simultaneous accepted push and pop leave count unchanged while both pointers advance.
REQ-027 Push and read together while empty: the push is accepted, the pop is ignored, and underflow_o is set.
REQ-028 Count: +1 on push only, -1 on pop only, otherwise unchanged; it never exceeds DEPTH and never goes below 0.
REQ-029 Write-then-read latency: a word pushed in cycle N appears on dout_o with empty_o = 0 in cycle N+1 when the FIFO was empty.
REQ-030 flush_i has priority over push and pop in the same cycle.
REQ-031 flush_i resets wr_ptr, rd_ptr and count to 0 and does not clear memory or the error flags.
REQ-032 err_clr_i clears overflow_o and underflow_o, except that a new error in the same cycle wins and the flag stays 1.
REQ-033 Ordering is strictly first-in, first-out; no entry is duplicated or lost except by overflow drop or flush.

Reset
REQ-034 While rst_ni = 0, asynchronously: wr_ptr = rd_ptr = count = 0, empty_o = 1, full_o = 0, almost_full_o = 0, count_o = 0, overflow_o = underflow_o = 0.
REQ-035 The memory array is not reset.
REQ-036 Reset asserted mid-operation discards all entries immediately; the first cycle after deassertion behaves as an empty FIFO.

Verification
REQ-037 Fill/drain, DEPTH=8: push 0x1..0x8 on consecutive cycles -> full_o = 1 after 8th push, almost_full_o = 1 from count 6; then pop 8 -> dout_o sequence 0x1..0x8, empty_o = 1.
REQ-038 Show-ahead: push 0xA5 to empty FIFO in cycle N -> cycle N+1 empty_o = 0, dout_o = 0xA5; read_i that cycle -> empty_o = 1 in N+2.
REQ-039 Overflow: when full, push 0xFF together with read_i -> pop occurs, 0xFF absent from the output stream, count = 7, overflow_o = 1; err_clr_i -> overflow_o = 0.
REQ-040 Wrap and concurrency: 20 cycles of push+pop at count 3 -> count stays 3, pointers wrap, output order is preserved.
REQ-041 Flush/reset: count 5, assert flush_i with push_i -> count 0 and the push is discarded; refill to 4, pulse rst_ni low mid-cycle -> empty_o = 1 immediately.
REQ-042 Underflow: read_i while empty -> underflow_o = 1, count stays 0, and the flag holds until err_clr_i.
